// File: rtl/serial_in_pkg.sv
// Shared types and constants for the serial-input transmitter.
package serial_in_pkg;

    localparam int SI_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } si_state_t;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Word FIFO with a combinational head read; pointers carry an extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_in_tx.sv
// Serial-input transmitter: buffers host words and presents one bit per core take.
//
//   state | meaning
//   IDLE  | shift register empty; loads the FIFO head when one is waiting
//   SHIFT | word in shift register; si_bit valid, advances on each si_take
module serial_in_tx
    import serial_in_pkg::*;
#(
    parameter int WIDTH = SI_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   si_take,
    input  logic                   si_lsb_first,
    output logic                   si_bit,
    output logic                   si_valid,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(WIDTH);

    si_state_t        state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic [CW-1:0]    bit_cnt, cnt_nx;
    logic             order, order_nx;
    logic             order_locked, locked_nx;
    logic             eff_order;
    logic             lsb_now;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout;

    assign wr_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_valid && wr_ready),
        .pop   (fifo_pop),
        .din   (wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (fifo_dout)
    );

    // Until the first take the order follows the live input; afterwards it is frozen.
    assign eff_order = order_locked ? order : si_lsb_first;
    assign lsb_now   = (eff_order == ORDER_LSB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            order        <= ORDER_MSB;
            order_locked <= 1'b0;
        end else begin
            state        <= state_nx;
            sr           <= sr_nx;
            bit_cnt      <= cnt_nx;
            order        <= order_nx;
            order_locked <= locked_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sr_nx     = sr;
        cnt_nx    = bit_cnt;
        order_nx  = order;
        locked_nx = order_locked;
        fifo_pop  = 1'b0;
        si_valid  = 1'b0;
        si_bit    = 1'b0;
        underrun  = 1'b0;

        case (state)
            IDLE: begin
                underrun = si_take;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sr_nx     = fifo_dout;
                    cnt_nx    = '0;
                    locked_nx = 1'b0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                si_valid = 1'b1;
                si_bit   = lsb_now ? sr[0] : sr[WIDTH-1];
                if (si_take) begin
                    if (!order_locked) begin
                        order_nx  = si_lsb_first;
                        locked_nx = 1'b1;
                    end
                    sr_nx  = lsb_now ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
                    cnt_nx = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        cnt_nx    = '0;
                        locked_nx = 1'b0;
                        if (!fifo_empty) begin
                            // Back-to-back reload keeps si_valid high across words.
                            fifo_pop = 1'b1;
                            sr_nx    = fifo_dout;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_in_tx.sv
// Self-checking bench for serial_in_tx: vector table plus scoreboard of expected bits.
module tb_serial_in_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        si_take;
    logic        si_lsb_first;
    logic        si_bit;
    logic        si_valid;
    logic        underrun;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    logic sbq[$];

    typedef struct {
        logic [15:0] word;
        logic        lsb;
        logic [15:0] seq;   // transmitted order, seq[15] first
    } vec_t;

    serial_in_tx #(.WIDTH(16), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .si_take      (si_take),
        .si_lsb_first (si_lsb_first),
        .si_bit       (si_bit),
        .si_valid     (si_valid),
        .underrun     (underrun),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check at negedge, advance past the next rising edge.
    task automatic step(input logic wv, input logic [15:0] wd, input logic [15:0] seq,
                        input logic tk, input logic lsb, output logic acc);
        logic exp_bit;
        wr_valid     = wv;
        wr_data      = wd;
        si_take      = tk;
        si_lsb_first = lsb;
        @(negedge clk);
        if (tk) begin
            check("si_valid_on_take", {31'b0, si_valid}, 32'd1);
            check("no_underrun_on_take", {31'b0, underrun}, 32'd0);
            if (sbq.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                exp_bit = sbq.pop_front();
                check("si_bit", {31'b0, si_bit}, {31'b0, exp_bit});
            end
        end
        acc = wv && wr_ready;
        if (acc) for (int i = 15; i >= 0; i--) sbq.push_back(seq[i]);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        si_take  = 1'b0;
    endtask

    task automatic idle_cycle();
        logic a;
        step(1'b0, 16'h0, 16'h0, 1'b0, si_lsb_first, a);
    endtask

    task automatic write_word(input logic [15:0] w, input logic [15:0] seq, input logic lsb);
        logic a;
        step(1'b1, w, seq, 1'b0, lsb, a);
        check("write_accepted", {31'b0, a}, 32'd1);
    endtask

    task automatic take_n(input int n, input logic lsb);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1, lsb, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_si_bit"},     {31'b0, si_bit},     32'd0);
        check({tag, "_si_valid"},   {31'b0, si_valid},   32'd0);
        check({tag, "_underrun"},   {31'b0, underrun},   32'd0);
        check({tag, "_fifo_count"}, {29'b0, fifo_count}, 32'd0);
        check({tag, "_wr_ready"},   {31'b0, wr_ready},   32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic a;
        int   guard;

        vecs[0] = '{word: 16'hA5C3, lsb: 1'b0, seq: 16'hA5C3};
        vecs[1] = '{word: 16'h0001, lsb: 1'b1, seq: 16'h8000};
        vecs[2] = '{word: 16'h8001, lsb: 1'b1, seq: 16'h8001};
        vecs[3] = '{word: 16'h1234, lsb: 1'b1, seq: 16'h2C48};
        vecs[4] = '{word: 16'h3C5A, lsb: 1'b0, seq: 16'h3C5A};
        vecs[5] = '{word: 16'h1234, lsb: 1'b0, seq: 16'h1234};

        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; si_take = 1'b0; si_lsb_first = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Take while idle: single-cycle underrun, nothing consumed.
        si_take = 1'b1;
        @(negedge clk);
        check("underrun_idle", {31'b0, underrun}, 32'd1);
        @(posedge clk); #1;
        si_take = 1'b0;
        @(negedge clk);
        check("underrun_cleared", {31'b0, underrun}, 32'd0);
        check("idle_fifo_count", {29'b0, fifo_count}, 32'd0);
        @(posedge clk); #1;

        // 8000 MSB first; take during the load cycle also underruns.
        write_word(16'h8000, 16'h8000, 1'b0);
        si_take = 1'b1;
        @(negedge clk);
        check("load_cycle_valid", {31'b0, si_valid}, 32'd0);
        check("underrun_load",    {31'b0, underrun}, 32'd1);
        @(posedge clk); #1;
        si_take = 1'b0;
        take_n(16, 1'b0);
        @(negedge clk);
        check("idle_after_8000", {31'b0, si_valid}, 32'd0);
        @(posedge clk); #1;

        // Table: write, load cycle, 16 takes in the record's order, back to idle.
        for (int v = 0; v < 6; v++) begin
            write_word(vecs[v].word, vecs[v].seq, vecs[v].lsb);
            @(negedge clk);
            check("latency_not_yet_valid", {31'b0, si_valid}, 32'd0);
            @(posedge clk); #1;
            take_n(16, vecs[v].lsb);
            @(negedge clk);
            check("table_idle", {31'b0, si_valid}, 32'd0);
            check("table_fifo_empty", {29'b0, fifo_count}, 32'd0);
            @(posedge clk); #1;
        end

        // Order stays locked when si_lsb_first flips mid-word.
        write_word(16'h0001, 16'h8000, 1'b1);
        idle_cycle();
        take_n(3, 1'b1);
        take_n(13, 1'b0);
        idle_cycle();

        // Back-to-back words with no bubble.
        write_word(16'hFFFF, 16'hFFFF, 1'b0);
        write_word(16'h0000, 16'h0000, 1'b0);
        take_n(32, 1'b0);
        @(negedge clk);
        check("b2b_idle", {31'b0, si_valid}, 32'd0);
        @(posedge clk); #1;

        // Fill: five words, no takes -> one in shift register, four queued.
        write_word(16'h1111, 16'h1111, 1'b0);
        write_word(16'h2222, 16'h2222, 1'b0);
        write_word(16'h3333, 16'h3333, 1'b0);
        write_word(16'h4444, 16'h4444, 1'b0);
        write_word(16'h5555, 16'h5555, 1'b0);
        @(negedge clk);
        check("full_count",    {29'b0, fifo_count}, 32'd4);
        check("full_wr_ready", {31'b0, wr_ready},   32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h6666, 16'h6666, 1'b0, 1'b0, a);
            check("stall_not_accepted", {31'b0, a}, 32'd0);
        end
        guard = 0;
        a = 1'b0;
        while (!a && guard < 40) begin
            step(1'b1, 16'h6666, 16'h6666, 1'b1, 1'b0, a);
            guard++;
        end
        check("sixth_accepted", {31'b0, a}, 32'd1);
        guard = 0;
        while (sbq.size() > 0 && guard < 200) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, a);
            guard++;
        end
        check("drain_done", {31'b0, sbq.size() == 0}, 32'd1);
        @(negedge clk);
        check("drain_idle", {31'b0, si_valid}, 32'd0);
        @(posedge clk); #1;

        // Async reset mid-word with two words queued.
        write_word(16'h1234, 16'h2C48, 1'b1);
        write_word(16'hBEEF, 16'hBEEF, 1'b1);
        write_word(16'hCAFE, 16'hCAFE, 1'b1);
        take_n(7, 1'b1);
        @(negedge clk);
        check("pre_reset_count", {29'b0, fifo_count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        @(posedge clk); #1;
        write_word(16'h8001, 16'h8001, 1'b1);
        idle_cycle();
        take_n(16, 1'b1);
        @(negedge clk);
        check("final_idle", {31'b0, si_valid}, 32'd0);
        check("sb_leftover", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_in_tx.md
Name: serial_in_tx

Overview:
- Transmitter end of the CPU's serial-input path. The core consumes one bit per serial-input instruction (RCL-form is MSB first, RCR-form is LSB first), signalled by the stage-1 SI enable.
- This block buffers 16-bit words from a host, presents the current bit on si_bit, and advances one bit per consume strobe.
- Sits between the host/testbench side and the core's serial-input pin.

Parameters:
- WIDTH, 16, word width in bits; matches the datapath.
- DEPTH, 4, word FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  WIDTH  host word to transmit.
- wr_valid  in  1  host offers wr_data.
- wr_ready  out  1  FIFO can accept a word; wr_ready = !fifo_full.
- si_take  in  1  core consumed the current bit this cycle (driven from SI enable).
- si_lsb_first  in  1  bit order of the consuming instruction (instruction bit 0: 1 = LSB first).
- si_bit  out  1  current serial bit presented to the core.
- si_valid  out  1  shift register holds untransmitted bits.
- underrun  out  1  single-cycle pulse when si_take arrives while si_valid = 0.
- fifo_count  out  $clog2(DEPTH)+1  words waiting in the FIFO, excluding the word in the shift register.

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - FIFO is emptied; shift register, bit counter, order latch and state are cleared.
  - Outputs: si_bit = 0, si_valid = 0, underrun = 0, fifo_count = 0, wr_ready = 1.
- Write: a word is accepted on an edge where wr_valid & wr_ready. There is no write when the FIFO is full, and wr_ready does not depend on a same-cycle pop.
- FSM states:
  - IDLE:
    - Entered from reset, or after the last bit when the FIFO is empty.
    - If fifo_count > 0, pop the FIFO head into the shift register on the next edge, set bit_cnt = 0, clear order_locked, and go to SHIFT.
  - SHIFT:
    - si_valid = 1.
    - Before the first take of a word (order_locked = 0): si_bit = si_lsb_first ? sr[0] : sr[WIDTH-1], combinationally.
    - On the first take, latch order = si_lsb_first and set order_locked.
    - After that: si_bit = order ? sr[0] : sr[WIDTH-1]. A changed si_lsb_first mid-word is ignored.
    - Each take: shift right if LSB-first, left if MSB-first; fill with 0; bit_cnt++.
    - Take with bit_cnt == WIDTH-1: if the FIFO is non-empty, reload from the head on the same edge and stay in SHIFT (no bubble); otherwise go to IDLE.
- Latency: a word written at edge N into an empty block gives si_valid = 1 after edge N+1. Its first bit is consumable at edge N+2 at the earliest.
- Underrun: si_take while si_valid = 0 (IDLE, or the load cycle) pulses underrun for 1 cycle. No state changes and no data is consumed.
- Simultaneous write and reload pop in the same cycle: fifo_count is unchanged and pointers advance independently. Pointers wrap modulo DEPTH.
- bit_cnt width is $clog2(WIDTH). It never exceeds WIDTH-1.

Decomposition:
- Package serial_in_pkg:
  - SI_WIDTH = 16
  - state enum {IDLE, SHIFT}
  - order encoding constants ORDER_MSB = 0, ORDER_LSB = 1
- Sub-module sync_fifo (WIDTH, DEPTH):
  - Ports: push, pop, full, empty, count, dout, showing the head word.
  - Combinational read of the head; pointers carry an extra wrap bit.
- Top level: FSM, shift register, order latch, underrun logic.

Test Plan:
- Reset, write 16'hA5C3, hold si_lsb_first = 0, take 16 times -> si_bit sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; then si_valid = 0 and the block is in IDLE.
- Write 16'h0001, si_lsb_first = 1 -> first bit 1, then 15 zeros. Toggle si_lsb_first to 0 after the 3rd take -> sequence unchanged (order stays locked).
- Write 16'hFFFF and 16'h0000 back-to-back, take on every cycle -> 16 ones then 16 zeros; si_valid never drops between the words.
- Write 5 words without taking, with DEPTH = 4 -> after the first word loads, fifo_count reaches 4 and wr_ready = 0; the 6th offer is stalled, not lost.
- Take while idle after reset -> underrun pulses for exactly 1 cycle; a following write of 16'h8000 with MSB first gives 1 then zeros.
- Assert rst_n low after 7 bits of 16'h1234 with 2 words queued -> outputs return to reset values immediately. A new write of 16'h8001 with LSB first transmits 1, fourteen 0s, then 1.
